// File: rtl/bus_master_arbiter.sv
// Round-robin master-side controller for the shared parallel bus: accepts one
// request at a time and sequences a 2-cycle read or a 1-cycle write.
module bus_master_arbiter #(
    parameter  int NUM_REQ          = 2,
    parameter  int ADDR_WIDTH       = 3,
    parameter  int DATA_WIDTH       = 8,
    parameter  int MAX_NO_OF_SLAVES = 4,
    parameter  int NO_OF_SLAVES     = 2,
    localparam int SID_W            = $clog2(MAX_NO_OF_SLAVES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*SID_W-1:0]       req_slave,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           busy,
    output logic [ADDR_WIDTH-1:0]          bus_addr,
    output logic                           bus_rd,
    output logic                           bus_wr,
    output logic [MAX_NO_OF_SLAVES-1:0]    bus_en,
    output logic [DATA_WIDTH-1:0]          bus_wdata,
    input  logic [DATA_WIDTH-1:0]          bus_m_rdata,
    output logic [1:0]                     dbg_state
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0]          REQ_ONE = 1;
    localparam logic [MAX_NO_OF_SLAVES-1:0] EN_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_RESP = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   r_owner;
    logic            r_bad;

    logic                        w_found;
    logic [GW-1:0]               w_winner;
    logic [GW-1:0]               w_idx;
    logic                        w_write;
    logic [SID_W-1:0]            w_slave;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [DATA_WIDTH-1:0]       w_wdata;
    logic                        w_slave_ok;
    logic [MAX_NO_OF_SLAVES-1:0] w_en;

    // Search starts one past the last grant and wraps, so every requester waits at most NUM_REQ-1 grants.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_write = 1'b0;
        w_slave = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == w_winner) begin
                w_write = req_write[i];
                w_slave = req_slave[i*SID_W +: SID_W];
                w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_slave_ok = (int'(w_slave) < NO_OF_SLAVES);
        w_en       = w_slave_ok ? (EN_ONE << w_slave) : '0;
    end

    // Gated by rst so the accept pulse also drops at once when reset asserts.
    assign req_ready = (rst && (r_state == IDLE) && w_found) ? (REQ_ONE << w_winner) : '0;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_owner      <= '0;
            r_bad        <= 1'b0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            bus_addr     <= '0;
            bus_rd       <= 1'b0;
            bus_wr       <= 1'b0;
            bus_en       <= '0;
            bus_wdata    <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_bad        <= !w_slave_ok;
                        bus_en       <= w_en;
                        bus_addr     <= w_addr;
                        if (w_write) begin
                            r_state   <= WRITE;
                            bus_wr    <= 1'b1;
                            bus_wdata <= w_wdata;
                        end else begin
                            r_state <= RD_ADDR;
                            bus_rd  <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    r_state <= RD_RESP;
                    bus_rd  <= 1'b0;
                end
                RD_RESP: begin
                    r_state   <= IDLE;
                    rsp_valid <= REQ_ONE << r_owner;
                    rsp_err   <= r_bad;
                    rsp_rdata <= r_bad ? '0 : bus_m_rdata;
                    bus_en    <= '0;
                    bus_addr  <= '0;
                end
                WRITE: begin
                    r_state   <= IDLE;
                    rsp_valid <= REQ_ONE << r_owner;
                    rsp_err   <= r_bad;
                    bus_wr    <= 1'b0;
                    bus_en    <= '0;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
